rect_motion_ctl: RTL
====================

// Module: rect_motion_ctl
// PURPOSE
//  Per-frame position controller for the rectangle drawing stage. The rectangle follows the mouse.
//  A mouse click drops it: it falls under gravity, bounces with damping on the bottom edge, then rests.
//  Sits beside the timing/draw pipeline; xpos_out/ypos_out drive the drawer's rectangle origin.
//  Positions change only at the start of vertical blanking, so a frame never shows a torn rectangle.
// PARAMETERS
//  SCREEN_W      800  visible width, pixels
//  SCREEN_H      600  visible height, pixels
//  RECT_W        50   rectangle width
//  RECT_H        50   rectangle height
//  GRAVITY       1    velocity increment per frame, px/frame
//  VEL_MAX       32   velocity saturation, px/frame (<=255)
//  BOUNCE_SHIFT  1    bounce damping: vel >> BOUNCE_SHIFT
//  VEL_STOP      2    post-bounce velocity below which motion ends
// PORTS
//  pclk        in   1   pixel clock; single clock domain
//  rst         in   1   synchronous reset, active-high
//  vblnk_in    in   1   vertical blank from timing; rising edge = frame tick
//  mouse_xpos  in   12  mouse x, pclk domain
//  mouse_ypos  in   12  mouse y, pclk domain
//  mouse_left  in   1   left button level, pclk domain
//  xpos_out    out  12  rectangle origin x
//  ypos_out    out  12  rectangle origin y
//  busy        out  1   1 while in FALL or RISE
// BEHAVIOUR
//  Reset values: state=FOLLOW, xpos_out=0, ypos_out=0, vel=0, busy=0, click_pend=0.
//  Reset also sets vblnk_d=1, so no tick fires until a true vblnk rise. Reset wins at any time.
//  tick = vblnk_in & ~vblnk_d. It is a one-cycle pulse. Outputs update on the cycle after the tick cycle.
//  click_pend sets on a mouse_left rising edge. It clears on any tick, whether or not it was consumed.
//  If the edge and the tick fall on the same cycle, the click counts for that tick.
//  Constants: X_MAX=SCREEN_W-RECT_W, Y_MAX=SCREEN_H-RECT_H. Arithmetic is 13-bit; vel is 8-bit unsigned.
//  Nothing happens between ticks except the click_pend update.
//  FOLLOW, on tick:
//   - xpos <= min(mouse_xpos,X_MAX); ypos <= min(mouse_ypos,Y_MAX).
//   - If click_pend: go to FALL, vel <= 0. The position is taken from this same tick.
//  FALL, on tick:
//   - vn = min(vel+GRAVITY, VEL_MAX); yn = ypos+vn.
//   - If yn < Y_MAX: ypos <= yn, vel <= vn.
//   - Otherwise: ypos <= Y_MAX, vb = vn>>BOUNCE_SHIFT.
//     If vb < VEL_STOP: go to REST, vel <= 0. Else: go to RISE, vel <= vb.
//  RISE, on tick:
//   - ypos <= (ypos>vel) ? ypos-vel : 0.
//   - If vel <= GRAVITY: go to FALL, vel <= 0. Else: vel <= vel-GRAVITY.
//  REST, on tick: if click_pend, go to FOLLOW. The position is held until the next tick.
//  Clicks are ignored in FALL and RISE, but click_pend still clears on each tick.
//  xpos_out is unchanged outside FOLLOW. Outputs are never above X_MAX/Y_MAX.
//  busy is registered with the state: busy = (state==FALL || state==RISE).
// STRUCTURE
//  Shared include rect_pkg.vh: SCREEN_W/H, RECT_W/H, and the state encodings
//  FOLLOW=2'd0, FALL=2'd1, RISE=2'd2, REST=2'd3.
//  The same constants are used by the draw stage.
//  One sub-module, edge_rise: a registered rising-edge detector with a reset value parameter.
//  It is instantiated twice: for vblnk_in (reset value 1) and for mouse_left (reset value 0).
//  The FSM and arithmetic stay in the top module.
// TESTING
//  1. Reset held with vblnk_in=1, then released -> no tick; outputs stay 0,0; busy=0.
//  2. FOLLOW, mouse=(900,700), vblnk rises -> 2 cycles later xpos=750, ypos=550. A mouse move mid-frame changes nothing.
//  3. Mouse (100,0), click, tick -> FALL. Over ticks 2..5, ypos = 1, 3, 6, 10 and busy=1.
//  4. Fall from 0 to Y_MAX -> clamps at 550. Bounce vel = vn>>1, then RISE decreasing to apex, then FALL.
//     Eventually REST at ypos=550 with busy=0.
//  5. Clicks during FALL/RISE are ignored. A click in REST, then a tick -> FOLLOW.
//     The next tick tracks the mouse, and no re-drop occurs without a new click.
//  6. rst asserted mid-RISE -> the next cycle shows FOLLOW, 0,0, busy=0, vel=0.
//     Velocity saturation is checked with VEL_MAX=4: vel never exceeds 4.

Source files
------------

// File: rtl/rect_motion_ctl_pkg.sv
// rtl/rect_motion_ctl_pkg.sv - shared screen/rectangle constants, FSM state type and helpers
// Purpose: constants shared with the draw stage, the controller state encoding and a
//          13-bit minimum helper used for clamping.
// Ports:   none (package).
package rect_motion_ctl_pkg;

  localparam int POS_W        = 12;
  localparam int ARITH_W      = 13;
  localparam int VEL_W        = 8;

  localparam int DEF_SCREEN_W = 800;
  localparam int DEF_SCREEN_H = 600;
  localparam int DEF_RECT_W   = 50;
  localparam int DEF_RECT_H   = 50;

  typedef enum logic [1:0] {
    ST_FOLLOW = 2'd0,
    ST_FALL   = 2'd1,
    ST_RISE   = 2'd2,
    ST_REST   = 2'd3
  } state_t;

  function automatic logic [ARITH_W-1:0] min13(input logic [ARITH_W-1:0] a,
                                               input logic [ARITH_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/rect_motion_ctl_if.sv
// rtl/rect_motion_ctl_if.sv - mouse/timing inputs and rectangle position outputs
// Purpose: bundles the frame timing, mouse and position signals of the motion controller.
// Signals: vblnk_in (frame blank), mouse_xpos/mouse_ypos/mouse_left (mouse state),
//          xpos_out/ypos_out (rectangle origin), busy (rectangle in flight).
// Modports: master drives timing/mouse and reads position; slave is the controller.
interface rect_motion_ctl_if
  import rect_motion_ctl_pkg::*;
;
  logic             vblnk_in;
  logic [POS_W-1:0] mouse_xpos;
  logic [POS_W-1:0] mouse_ypos;
  logic             mouse_left;
  logic [POS_W-1:0] xpos_out;
  logic [POS_W-1:0] ypos_out;
  logic             busy;

  modport master (
    output vblnk_in, mouse_xpos, mouse_ypos, mouse_left,
    input  xpos_out, ypos_out, busy
  );

  modport slave (
    input  vblnk_in, mouse_xpos, mouse_ypos, mouse_left,
    output xpos_out, ypos_out, busy
  );

endinterface

// File: rtl/rect_motion_ctl_edge_rise.sv
// rtl/rect_motion_ctl_edge_rise.sv - registered rising-edge detector
// Purpose: one-cycle pulse when i_sig goes 0->1 relative to its registered copy.
//          RESET_VAL sets the assumed previous level after reset, so a signal that is
//          already high when reset releases produces no pulse when RESET_VAL=1.
// Ports:   i_clk, i_rst (sync, active-high), i_sig (level in), o_rise (edge pulse out).
module rect_motion_ctl_edge_rise #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sig_d <= RESET_VAL;
    end else begin
      r_sig_d <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_sig_d;

endmodule

// File: rtl/rect_motion_ctl.sv
// rtl/rect_motion_ctl.sv - per-frame rectangle position controller (follow / drop / bounce)
// Purpose: rectangle follows the mouse; a click drops it under gravity, it bounces with
//          damping on the bottom edge and comes to rest. All state changes happen on the
//          frame tick (vblank rising edge) so a displayed frame never sees a moving origin.
// Ports:   i_pclk (pixel clock), i_rst (sync, active-high),
//          io_bus (slave): vblnk_in, mouse_xpos, mouse_ypos, mouse_left in;
//                          xpos_out, ypos_out, busy out.
module rect_motion_ctl
  import rect_motion_ctl_pkg::*;
#(
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H,
  parameter int RECT_W       = DEF_RECT_W,
  parameter int RECT_H       = DEF_RECT_H,
  parameter int GRAVITY      = 1,
  parameter int VEL_MAX      = 32,
  parameter int BOUNCE_SHIFT = 1,
  parameter int VEL_STOP     = 2
) (
  input  logic             i_pclk,
  input  logic             i_rst,
  rect_motion_ctl_if.slave io_bus
);

  localparam logic [ARITH_W-1:0] X_MAX   = ARITH_W'(SCREEN_W - RECT_W);
  localparam logic [ARITH_W-1:0] Y_MAX   = ARITH_W'(SCREEN_H - RECT_H);
  localparam logic [ARITH_W-1:0] C_GRAV  = ARITH_W'(GRAVITY);
  localparam logic [ARITH_W-1:0] C_VMAX  = ARITH_W'(VEL_MAX);
  localparam logic [ARITH_W-1:0] C_VSTOP = ARITH_W'(VEL_STOP);
  localparam logic [VEL_W-1:0]   C_GRAV8 = VEL_W'(GRAVITY);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [POS_W-1:0]   r_xpos;
  logic [POS_W-1:0]   w_xpos_nxt;
  logic [POS_W-1:0]   r_ypos;
  logic [POS_W-1:0]   w_ypos_nxt;
  logic [VEL_W-1:0]   r_vel;
  logic [VEL_W-1:0]   w_vel_nxt;
  logic               r_busy;
  logic               r_click_pend;

  logic               w_tick;
  logic               w_click_edge;
  logic               w_click;
  logic [ARITH_W-1:0] w_vel13;
  logic [ARITH_W-1:0] w_ypos13;
  logic [ARITH_W-1:0] w_vn;
  logic [ARITH_W-1:0] w_yn;
  logic [ARITH_W-1:0] w_vb;

  // vblank detector resets to 1 so a vblank already high at reset release is not a tick.
  rect_motion_ctl_edge_rise #(.RESET_VAL(1'b1)) u_vblnk_edge (
    .i_clk  (i_pclk),
    .i_rst  (i_rst),
    .i_sig  (io_bus.vblnk_in),
    .o_rise (w_tick)
  );

  rect_motion_ctl_edge_rise #(.RESET_VAL(1'b0)) u_click_edge (
    .i_clk  (i_pclk),
    .i_rst  (i_rst),
    .i_sig  (io_bus.mouse_left),
    .o_rise (w_click_edge)
  );

  // A click edge landing on the tick cycle still counts for that tick.
  assign w_click  = r_click_pend | w_click_edge;

  assign w_vel13  = {{(ARITH_W-VEL_W){1'b0}}, r_vel};
  assign w_ypos13 = {1'b0, r_ypos};
  assign w_vn     = min13(w_vel13 + C_GRAV, C_VMAX);
  assign w_yn     = w_ypos13 + w_vn;
  assign w_vb     = w_vn >> BOUNCE_SHIFT;

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_state      <= ST_FOLLOW;
      r_xpos       <= '0;
      r_ypos       <= '0;
      r_vel        <= '0;
      r_busy       <= 1'b0;
      r_click_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_xpos       <= w_xpos_nxt;
      r_ypos       <= w_ypos_nxt;
      r_vel        <= w_vel_nxt;
      r_busy       <= (w_state_nxt == ST_FALL) || (w_state_nxt == ST_RISE);
      // Every tick clears the pending click, consumed or not.
      r_click_pend <= w_tick ? 1'b0 : w_click;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_xpos_nxt  = r_xpos;
    w_ypos_nxt  = r_ypos;
    w_vel_nxt   = r_vel;
    if (w_tick) begin
      unique case (r_state)
        ST_FOLLOW: begin
          w_xpos_nxt = POS_W'(min13({1'b0, io_bus.mouse_xpos}, X_MAX));
          w_ypos_nxt = POS_W'(min13({1'b0, io_bus.mouse_ypos}, Y_MAX));
          if (w_click) begin
            w_state_nxt = ST_FALL;
            w_vel_nxt   = '0;
          end
        end
        ST_FALL: begin
          if (w_yn < Y_MAX) begin
            w_ypos_nxt = POS_W'(w_yn);
            w_vel_nxt  = VEL_W'(w_vn);
          end else begin
            w_ypos_nxt = POS_W'(Y_MAX);
            if (w_vb < C_VSTOP) begin
              w_state_nxt = ST_REST;
              w_vel_nxt   = '0;
            end else begin
              w_state_nxt = ST_RISE;
              w_vel_nxt   = VEL_W'(w_vb);
            end
          end
        end
        ST_RISE: begin
          w_ypos_nxt = (w_ypos13 > w_vel13) ? (r_ypos - POS_W'(r_vel)) : '0;
          if (r_vel <= C_GRAV8) begin
            w_state_nxt = ST_FALL;
            w_vel_nxt   = '0;
          end else begin
            w_vel_nxt   = r_vel - C_GRAV8;
          end
        end
        ST_REST: begin
          if (w_click) begin
            w_state_nxt = ST_FOLLOW;
          end
        end
        default: begin
          w_state_nxt = ST_FOLLOW;
        end
      endcase
    end
  end

  assign io_bus.xpos_out = r_xpos;
  assign io_bus.ypos_out = r_ypos;
  assign io_bus.busy     = r_busy;

endmodule
